locked_reg_bank_v2: RTL and testbench

Parametrised register bank with per-entry sticky write locks and a two-step global seal. It replaces the single-lock, all-entries-uniform bank.
- Accepts one request per handshake: write, read, lock-entry, or seal step.
- Returns one response per request, carrying an error flag.
- Counts attempted writes to locked entries.
- Sits behind the config bus decoder; its outputs feed security-critical datapath configuration.

---
 rtl/locked_reg_bank_pkg.sv | 28 ++
 rtl/locked_reg_bank_seal_fsm.sv | 54 +++++
 rtl/locked_reg_bank_v2.sv | 133 +++++++++++++
 tb/tb_locked_reg_bank_v2.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/locked_reg_bank_pkg.sv
// Shared types for the locked register bank: request opcodes,
// seal FSM states, response bundle and the default seal key.
package locked_reg_bank_pkg;

  typedef enum logic [1:0] {
    OP_WRITE = 2'b00,
    OP_READ  = 2'b01,
    OP_LOCK  = 2'b10,
    OP_SEAL  = 2'b11
  } req_op_e;

  typedef enum logic [1:0] {
    ST_OPEN   = 2'b00,
    ST_ARMED  = 2'b01,
    ST_SEALED = 2'b10
  } seal_state_e;

  // Widest entry the response bundle can carry.
  localparam int MAX_DATA_W = 64;

  localparam logic [31:0] DEF_ARM_KEY = 32'hC0DE_1262;

  typedef struct packed {
    logic [MAX_DATA_W-1:0] rdata;
    logic                  err;
  } resp_t;

endpackage

// File: rtl/locked_reg_bank_seal_fsm.sv
// Two-step global seal: correct key arms, inverted key seals.
// Any other accepted request while armed drops back to open.
module locked_reg_bank_seal_fsm
  import locked_reg_bank_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        accept,
  input  logic        is_seal,
  input  logic        key_match,
  input  logic        inv_key_match,
  output logic        sealed,
  output logic        seal_err,
  output seal_state_e state
);

  seal_state_e nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_OPEN;
    end else begin
      state <= nxt;
    end
  end

  always_comb begin
    nxt      = state;
    seal_err = 1'b0;
    if (accept) begin
      unique case (state)
        ST_OPEN: begin
          if (is_seal) begin
            if (key_match) nxt = ST_ARMED;
            else           seal_err = 1'b1;
          end
        end
        ST_ARMED: begin
          if (is_seal && inv_key_match) begin
            nxt = ST_SEALED;
          end else begin
            nxt      = ST_OPEN;
            seal_err = is_seal;
          end
        end
        ST_SEALED: nxt = ST_SEALED;
        default:   nxt = ST_OPEN;
      endcase
    end
  end

  assign sealed = (state == ST_SEALED);

endmodule

// File: rtl/locked_reg_bank_v2.sv
// Register bank with sticky per-entry write locks, a global seal,
// a saturating blocked-write counter and a one-deep response buffer.
module locked_reg_bank_v2
  import locked_reg_bank_pkg::*;
#(
  parameter int                N_REGS    = 4,
  parameter int                DATA_W    = 32,
  parameter int                ADDR_W    = $clog2(N_REGS),
  parameter int                VIOL_W    = 8,
  parameter logic [DATA_W-1:0] RESET_VAL = '0,
  parameter logic [DATA_W-1:0] ARM_KEY   = DATA_W'(DEF_ARM_KEY)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [1:0]               req_op,
  input  logic [ADDR_W-1:0]        req_addr,
  input  logic [DATA_W-1:0]        req_wdata,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [DATA_W-1:0]        resp_rdata,
  output logic                     resp_err,
  output logic [N_REGS-1:0]        lock_vec,
  output logic                     sealed,
  output logic [VIOL_W-1:0]        viol_count,
  output logic [N_REGS*DATA_W-1:0] reg_flat
);

  logic [DATA_W-1:0] regs [N_REGS];

  req_op_e     op;
  seal_state_e seal_st;
  resp_t       resp_q;
  resp_t       resp_d;

  logic accept;
  logic addr_ok;
  logic locked;
  logic is_wr, is_rd, is_lk, is_sl;
  logic seal_err;
  logic wr_en, lk_en, viol_inc;
  logic unused_bits;

  assign req_ready = !resp_valid || resp_ready;
  assign accept    = req_valid && req_ready;

  assign op    = req_op_e'(req_op);
  assign is_wr = (op == OP_WRITE);
  assign is_rd = (op == OP_READ);
  assign is_lk = (op == OP_LOCK);
  assign is_sl = (op == OP_SEAL);

  assign addr_ok = 32'(req_addr) < 32'(N_REGS);
  assign locked  = addr_ok && (lock_vec[req_addr] || sealed);

  locked_reg_bank_seal_fsm u_seal (
    .clk           (clk),
    .rst_n         (rst_n),
    .accept        (accept),
    .is_seal       (is_sl),
    .key_match     (req_wdata == ARM_KEY),
    .inv_key_match (req_wdata == ~ARM_KEY),
    .sealed        (sealed),
    .seal_err      (seal_err),
    .state         (seal_st)
  );

  always_comb begin
    resp_d   = '0;
    wr_en    = 1'b0;
    lk_en    = 1'b0;
    viol_inc = 1'b0;
    unique case (1'b1)
      is_wr: begin
        if (!addr_ok) begin
          resp_d.err = 1'b1;
        end else if (locked) begin
          resp_d.err = 1'b1;
          viol_inc   = 1'b1;
        end else begin
          wr_en = 1'b1;
        end
      end
      is_rd: begin
        if (!addr_ok) resp_d.err   = 1'b1;
        else          resp_d.rdata = MAX_DATA_W'(regs[req_addr]);
      end
      is_lk: begin
        if (!addr_ok) resp_d.err = 1'b1;
        else          lk_en      = 1'b1;
      end
      is_sl: resp_d.err = seal_err;
      default: resp_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N_REGS; i++) regs[i] <= RESET_VAL;
      lock_vec   <= '0;
      viol_count <= '0;
    end else if (accept) begin
      if (wr_en) regs[req_addr] <= req_wdata;
      if (lk_en) lock_vec[req_addr] <= 1'b1;
      if (viol_inc && (viol_count != '1))
        viol_count <= viol_count + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      resp_valid <= 1'b0;
      resp_q     <= '0;
    end else if (accept) begin
      resp_valid <= 1'b1;
      resp_q     <= resp_d;
    end else if (resp_ready) begin
      resp_valid <= 1'b0;
    end
  end

  assign resp_rdata = resp_q.rdata[DATA_W-1:0];
  assign resp_err   = resp_q.err;

  // Upper response bits beyond DATA_W and the FSM state are not exported.
  assign unused_bits = ^{resp_q.rdata, seal_st};

  for (genvar g = 0; g < N_REGS; g++) begin : g_flat
    assign reg_flat[g*DATA_W +: DATA_W] = regs[g];
  end

endmodule

// File: tb/tb_locked_reg_bank_v2.sv
// Directed plus randomized bench for locked_reg_bank_v2 against a
// behavioural model; two instances cover default and small configs.
module tb_locked_reg_bank_v2;

  localparam logic [31:0] KEY = 32'hC0DE_1262;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, req_valid, resp_ready;
  logic [1:0]  req_op, req_addr;
  logic [31:0] req_wdata;

  logic        rr0, rr1, rv0, rv1, re0, re1, sl0, sl1;
  logic [31:0] rd0, rd1;
  logic [3:0]  lv0;
  logic [2:0]  lv1;
  logic [7:0]  vc0;
  logic [1:0]  vc1;
  logic [127:0] rf0;
  logic [95:0]  rf1;

  locked_reg_bank_v2 u0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rr0),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(rv0), .resp_ready(resp_ready), .resp_rdata(rd0),
    .resp_err(re0), .lock_vec(lv0), .sealed(sl0), .viol_count(vc0),
    .reg_flat(rf0)
  );

  locked_reg_bank_v2 #(.N_REGS(3), .VIOL_W(2)) u1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rr1),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(rv1), .resp_ready(resp_ready), .resp_rdata(rd1),
    .resp_err(re1), .lock_vec(lv1), .sealed(sl1), .viol_count(vc1),
    .reg_flat(rf1)
  );

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 0;
  bit rnd = 0;

  // Behavioural model: k=0 is the 4-entry bank, k=1 the 3-entry one.
  int          nr[2]   = '{4, 3};
  int          vmax[2] = '{255, 3};
  logic [31:0] m_reg[2][4];
  bit          m_lock[2][4];
  int          m_st[2];
  int          m_viol[2];
  logic [31:0] e_rd[2];
  bit          e_err[2];
  bit          ev;

  function automatic void chk(input string nm, input logic [127:0] act,
                              input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic void m_reset();
    ev = 0;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 4; i++) begin
        m_reg[k][i]  = '0;
        m_lock[k][i] = 0;
      end
      m_st[k] = 0; m_viol[k] = 0; e_rd[k] = '0; e_err[k] = 0;
    end
  endfunction

  function automatic void m_exec(input int k);
    logic [31:0] rd;
    bit err, va;
    rd  = '0;
    err = 0;
    va  = int'(req_addr) < nr[k];
    case (req_op)
      2'd0: begin
        if (!va) err = 1;
        else if (m_lock[k][req_addr] || m_st[k] == 2) begin
          err = 1;
          if (m_viol[k] < vmax[k]) m_viol[k]++;
        end else m_reg[k][req_addr] = req_wdata;
      end
      2'd1: if (!va) err = 1; else rd = m_reg[k][req_addr];
      2'd2: if (!va) err = 1; else m_lock[k][req_addr] = 1;
      default: ;
    endcase
    if (m_st[k] == 0) begin
      if (req_op == 2'd3) begin
        if (req_wdata == KEY) m_st[k] = 1;
        else err = 1;
      end
    end else if (m_st[k] == 1) begin
      if (req_op == 2'd3 && req_wdata == ~KEY) m_st[k] = 2;
      else begin
        m_st[k] = 0;
        if (req_op == 2'd3) err = 1;
      end
    end
    e_rd[k]  = rd;
    e_err[k] = err;
  endfunction

  always @(posedge clk) begin : model
    bit acc;
    acc = req_valid && (!ev || resp_ready);
    if (!rst_n) m_reset();
    else begin
      if (ev && resp_ready) ev = 0;
      if (acc) begin
        ev = 1;
        m_exec(0);
        m_exec(1);
      end
    end
  end

  always @(negedge clk) begin : compare
    logic [127:0] f0, f1;
    logic [3:0] l0;
    logic [2:0] l1;
    if (chk_en) begin
      f0 = '0; f1 = '0; l0 = '0; l1 = '0;
      for (int i = 0; i < 4; i++) begin
        f0[i*32 +: 32] = m_reg[0][i];
        l0[i] = m_lock[0][i];
      end
      for (int i = 0; i < 3; i++) begin
        f1[i*32 +: 32] = m_reg[1][i];
        l1[i] = m_lock[1][i];
      end
      chk("req_ready0", 128'(rr0), 128'(!ev || resp_ready));
      chk("req_ready1", 128'(rr1), 128'(!ev || resp_ready));
      chk("resp_valid0", 128'(rv0), 128'(ev));
      chk("resp_valid1", 128'(rv1), 128'(ev));
      if (ev) begin
        chk("rdata0", 128'(rd0), 128'(e_rd[0]));
        chk("rdata1", 128'(rd1), 128'(e_rd[1]));
        chk("err0", 128'(re0), 128'(e_err[0]));
        chk("err1", 128'(re1), 128'(e_err[1]));
      end
      chk("sealed0", 128'(sl0), 128'(m_st[0] == 2));
      chk("sealed1", 128'(sl1), 128'(m_st[1] == 2));
      chk("viol0", 128'(vc0), 128'(m_viol[0]));
      chk("viol1", 128'(vc1), 128'(m_viol[1]));
      chk("lock0", 128'(lv0), 128'(l0));
      chk("lock1", 128'(lv1), 128'(l1));
      chk("regs0", rf0, f0);
      chk("regs1", 128'(rf1), f1);
    end
  end

  always @(posedge clk) begin
    if (rnd) begin
      #2;
      resp_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic send(input logic [1:0] op, input logic [1:0] a,
                      input logic [31:0] d);
    int n;
    req_valid = 1; req_op = op; req_addr = a; req_wdata = d;
    n = 0;
    forever begin
      @(negedge clk);
      if (rr0) break;
      n++;
      if (n > 100) begin
        vectors++; miscompares++;
        $display("FAIL send_timeout: got ready=0 expected ready=1");
        break;
      end
    end
    @(posedge clk); #2;
    req_valid = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    @(posedge clk); #2;
    rst_n = 1;
  endtask

  task automatic realign();
    @(posedge clk); #2;
  endtask

  initial begin
    rst_n = 0; req_valid = 0; req_op = 0; req_addr = 0;
    req_wdata = 0; resp_ready = 1;
    repeat (2) @(posedge clk);
    #2 rst_n = 1; chk_en = 1;
    @(negedge clk);
    chk("pin_rst_viol", 128'(vc0), 128'(8'd0));
    chk("pin_rst_lock", 128'(lv0), 128'(4'd0));
    chk("pin_rst_valid", 128'(rv0), 128'(1'b0));
    chk("pin_rst_regs", rf0, 128'd0);
    realign();

    send(2'd1, 2'd2, 32'h0);
    @(negedge clk);
    chk("pin_rd_reset", 128'(rd0), 128'(32'h0));
    realign();
    send(2'd0, 2'd2, 32'h1234_5678);
    send(2'd1, 2'd2, 32'h0);
    @(negedge clk);
    chk("pin_rd_back", 128'(rd0), 128'(32'h1234_5678));
    chk("pin_rd_err", 128'(re0), 128'(1'b0));
    realign();

    send(2'd2, 2'd1, 32'h0);
    send(2'd0, 2'd1, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("pin_lock_err", 128'(re0), 128'(1'b1));
    chk("pin_lock_viol", 128'(vc0), 128'(8'd1));
    chk("pin_lock_keep", 128'(rf0[63:32]), 128'(32'h0));
    realign();
    send(2'd0, 2'd0, 32'hAA);
    @(negedge clk);
    chk("pin_indep_err", 128'(re0), 128'(1'b0));
    realign();

    do_reset();
    send(2'd3, 2'd0, KEY);
    send(2'd3, 2'd0, 32'h3F21_ED9D);
    @(negedge clk);
    chk("pin_seal", 128'(sl0), 128'(1'b1));
    chk("pin_seal_err", 128'(re0), 128'(1'b0));
    realign();
    for (int a = 0; a < 4; a++) send(2'd0, 2'(a), $urandom);
    @(negedge clk);
    chk("pin_sealed_viol", 128'(vc0), 128'(8'd4));
    chk("pin_sealed_regs", rf0, 128'd0);
    chk("pin_sealed_viol_n3", 128'(vc1), 128'(2'd3));
    realign();

    do_reset();
    send(2'd3, 2'd0, KEY);
    send(2'd0, 2'd3, 32'h55);
    send(2'd3, 2'd0, 32'h3F21_ED9D);
    @(negedge clk);
    chk("pin_abort_err", 128'(re0), 128'(1'b1));
    chk("pin_abort_open", 128'(sl0), 128'(1'b0));
    chk("pin_abort_wr", 128'(rf0[127:96]), 128'(32'h55));
    realign();

    realign();
    resp_ready = 0;
    send(2'd0, 2'd0, 32'h77);
    req_valid = 1; req_op = 2'd0; req_addr = 2'd1; req_wdata = 32'h99;
    repeat (3) begin
      @(negedge clk);
      chk("pin_stall_ready", 128'(rr0), 128'(1'b0));
      chk("pin_stall_valid", 128'(rv0), 128'(1'b1));
    end
    chk("pin_stall_noacc", 128'(rf0[63:32]), 128'(32'h0));
    realign();
    do_reset();
    req_valid = 0; resp_ready = 1;
    @(negedge clk);
    chk("pin_stall_rst_valid", 128'(rv0), 128'(1'b0));
    chk("pin_stall_rst_regs", rf0, 128'd0);
    realign();

    do_reset();
    send(2'd2, 2'd0, 32'h0);
    repeat (5) send(2'd0, 2'd0, $urandom);
    @(negedge clk);
    chk("pin_sat_n3", 128'(vc1), 128'(2'd3));
    chk("pin_sat_n4", 128'(vc0), 128'(8'd5));
    realign();
    send(2'd0, 2'd3, 32'h1);
    @(negedge clk);
    chk("pin_badaddr_err", 128'(re1), 128'(1'b1));
    chk("pin_badaddr_viol", 128'(vc1), 128'(2'd3));
    chk("pin_goodaddr_err", 128'(re0), 128'(1'b0));
    realign();

    rnd = 1;
    for (int it = 0; it < 600; it++) begin
      logic [1:0]  op;
      logic [31:0] d;
      op = 2'($urandom_range(0, 3));
      d  = $urandom;
      if (op == 2'd3) begin
        case ($urandom_range(0, 2))
          0: d = KEY;
          1: d = ~KEY;
          default: ;
        endcase
      end
      if ($urandom_range(0, 59) == 0) do_reset();
      send(op, 2'($urandom_range(0, 3)), d);
      if ($urandom_range(0, 4) == 0) realign();
    end
    rnd = 0;
    #3 resp_ready = 1;
    repeat (3) realign();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
